// File: rtl/core_timer_sched.sv
// core_timer_sched: shares the core_timer_regs register port between host
// accesses and a hardware auto-reload engine. On a timer interrupt the engine
// advances mtimecmp by `period` using the glitch-free write order
// low=all-ones, high, low, so software receives a periodic tick.
//
// Optional feature macro: CORE_TIMER_SCHED_SKIP_EN
//   defined   : a reload that would still land at or before mtime is pushed
//               to mtime + period instead (missed ticks are skipped).
//   undefined : mtimecmp always advances by exactly one period (catch-up).
//
// AXI_DATA_WIDTH is expected to be 32: mtimecmp is handled as two words.
module core_timer_sched #(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [15:0] MTIMECMP_ADDR  = 16'h0008
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      host_wr_req,
  input  logic                      host_rd_req,
  input  logic [15:0]               host_addr,
  input  logic [AXI_DATA_WIDTH-1:0] host_wdata,
  output logic                      host_ready,
  output logic [AXI_DATA_WIDTH-1:0] host_rdata,
  output logic                      host_rdata_valid,
  input  logic                      auto_en,
  input  logic [AXI_DATA_WIDTH-1:0] period,
  input  logic                      timer_int,
  input  logic [63:0]               mtime,
  output logic                      reg_valid_write,
  output logic                      reg_valid_read,
  output logic [15:0]               reg_addr,
  output logic [AXI_DATA_WIDTH-1:0] reg_wdata,
  input  logic [AXI_DATA_WIDTH-1:0] reg_rdata,
  input  logic                      reg_rdata_valid,
  output logic                      busy,
  output logic [15:0]               reload_cnt
);

  localparam logic [15:0] MTIMECMPH_ADDR = MTIMECMP_ADDR + 16'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    WR_LMAX = 3'd2,
    WR_H    = 3'd3,
    WR_L    = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t      state;
  logic [63:0] cmp_sh;
  logic [63:0] nxt;
  logic [15:0] reload_cnt_q;
  logic        trig;
  logic        pass;

`ifdef CORE_TIMER_SCHED_SKIP_EN
  // Next compare value; a target already in the past jumps ahead of mtime.
  function automatic logic [63:0] next_cmp(input logic [63:0] cmp,
                                           input logic [AXI_DATA_WIDTH-1:0] per,
                                           input logic [63:0] now);
    logic [63:0] sum;
    sum = cmp + 64'(per);
    if (sum <= now) begin
      return now + 64'(per);
    end
    return sum;
  endfunction
`else
  // Next compare value; advances exactly one period, wrapping modulo 2^64.
  function automatic logic [63:0] next_cmp(input logic [63:0] cmp,
                                           input logic [AXI_DATA_WIDTH-1:0] per);
    return cmp + 64'(per);
  endfunction

  // mtime only matters when skipping missed ticks.
  logic unused_mtime;
  assign unused_mtime = ^mtime;
`endif

  // The engine claims the port in the same IDLE cycle it sees the interrupt.
  assign trig = (state == IDLE) & auto_en & timer_int & (period != '0);
  assign pass = (state == IDLE) & ~trig & ~ARESET;

  // Reload sequencer, shadow of mtimecmp and completed-reload counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      cmp_sh       <= '1;
      nxt          <= '0;
      reload_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state <= CALC;
          end else if (host_wr_req) begin
            if (host_addr == MTIMECMP_ADDR)  cmp_sh[31:0]  <= host_wdata;
            if (host_addr == MTIMECMPH_ADDR) cmp_sh[63:32] <= host_wdata;
          end
        end
        CALC: begin
`ifdef CORE_TIMER_SCHED_SKIP_EN
          nxt <= next_cmp(cmp_sh, period, mtime);
`else
          nxt <= next_cmp(cmp_sh, period);
`endif
          state <= WR_LMAX;
        end
        WR_LMAX: state <= WR_H;
        WR_H:    state <= WR_L;
        WR_L: begin
          cmp_sh       <= nxt;
          reload_cnt_q <= reload_cnt_q + 16'd1;
          state        <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register-port mux: host pass-through in IDLE, engine writes otherwise.
  always_comb begin
    reg_valid_write  = 1'b0;
    reg_valid_read   = 1'b0;
    reg_addr         = '0;
    reg_wdata        = '0;
    host_rdata       = '0;
    host_rdata_valid = 1'b0;
    if (pass) begin
      reg_valid_write  = host_wr_req;
      reg_valid_read   = host_rd_req;
      reg_addr         = host_addr;
      reg_wdata        = host_wdata;
      host_rdata       = reg_rdata;
      host_rdata_valid = reg_rdata_valid;
    end else if (!ARESET) begin
      case (state)
        WR_LMAX: begin
          reg_valid_write = 1'b1;
          reg_addr        = MTIMECMP_ADDR;
          reg_wdata       = '1;
        end
        WR_H: begin
          reg_valid_write = 1'b1;
          reg_addr        = MTIMECMPH_ADDR;
          reg_wdata       = nxt[63:32];
        end
        WR_L: begin
          reg_valid_write = 1'b1;
          reg_addr        = MTIMECMP_ADDR;
          reg_wdata       = nxt[31:0];
        end
        default: ;
      endcase
    end
  end

  // Status outputs are held at zero during the reset cycle.
  assign host_ready = pass;
  assign busy       = (state != IDLE) & ~ARESET;
  assign reload_cnt = ARESET ? 16'd0 : reload_cnt_q;

endmodule

// File: tb/tb_core_timer_sched.sv
module tb_core_timer_sched;

  localparam logic [15:0] CMP   = 16'h0008;
  localparam logic [15:0] CMPH  = 16'h000C;
  localparam logic [15:0] MTL   = 16'h0000;
  localparam logic [15:0] MTH   = 16'h0004;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        host_wr_req, host_rd_req;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ready;
  logic [31:0] host_rdata;
  logic        host_rdata_valid;
  logic        auto_en;
  logic [31:0] period;
  logic        timer_int;
  logic [63:0] mtime;
  logic        reg_valid_write, reg_valid_read;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rdata_valid;
  logic        busy;
  logic [15:0] reload_cnt;

  int checks = 0;
  int errors = 0;

  // Simple timer register block model
  logic [63:0] mtimecmp_m;

  core_timer_sched #(.AXI_DATA_WIDTH(32), .MTIMECMP_ADDR(CMP)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rdata(host_rdata),
    .host_rdata_valid(host_rdata_valid),
    .auto_en(auto_en), .period(period), .timer_int(timer_int), .mtime(mtime),
    .reg_valid_write(reg_valid_write), .reg_valid_read(reg_valid_read),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rdata_valid(reg_rdata_valid),
    .busy(busy), .reload_cnt(reload_cnt)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (ARESET) mtimecmp_m <= '1;
    else if (reg_valid_write) begin
      if (reg_addr == CMP)  mtimecmp_m[31:0]  <= reg_wdata;
      if (reg_addr == CMPH) mtimecmp_m[63:32] <= reg_wdata;
    end
  end

  assign timer_int       = (mtime >= mtimecmp_m);
  assign reg_rdata_valid = reg_valid_read;
  always_comb begin
    reg_rdata = 32'h0;
    case (reg_addr)
      MTL:  reg_rdata = mtime[31:0];
      MTH:  reg_rdata = mtime[63:32];
      CMP:  reg_rdata = mtimecmp_m[31:0];
      CMPH: reg_rdata = mtimecmp_m[63:32];
      default: reg_rdata = 32'h0;
    endcase
  end

  task automatic test_reset;
    @(posedge ACLK); #1;
    ARESET = 1; host_wr_req = 1; host_rd_req = 1; host_addr = CMP; host_wdata = 32'h55;
    auto_en = 0; period = 0; mtime = 0;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", host_ready); end
    checks++; if (reg_valid_write !== 1'b0 || reg_valid_read !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b want 00", reg_valid_write, reg_valid_read); end
    checks++; if (busy !== 1'b0 || reload_cnt !== 16'd0) begin errors++; $display("FAIL reset_status got busy %b cnt %0d want 0 0", busy, reload_cnt); end
    @(posedge ACLK); #1;
    ARESET = 0; host_wr_req = 0; host_rd_req = 0;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got ready %b busy %b want 1 0", host_ready, busy); end
  endtask

  task automatic test_passthrough;
    @(posedge ACLK); #1;
    host_wr_req = 1; host_addr = CMP; host_wdata = 32'h100;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b1 || reg_valid_write !== 1'b1 || reg_addr !== CMP || reg_wdata !== 32'h100)
      begin errors++; $display("FAIL pass_wr_lo got rdy %b wr %b %h=%h want 1 1 %h=100", host_ready, reg_valid_write, reg_addr, reg_wdata, CMP); end
    @(posedge ACLK); #1;
    host_addr = CMPH; host_wdata = 32'h0;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b1 || reg_valid_write !== 1'b1 || reg_addr !== CMPH || reg_wdata !== 32'h0)
      begin errors++; $display("FAIL pass_wr_hi got rdy %b wr %b %h=%h want 1 1 %h=0", host_ready, reg_valid_write, reg_addr, reg_wdata, CMPH); end
    @(posedge ACLK); #1;
    host_wr_req = 0; mtime = 64'h101;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      checks++; if (timer_int !== 1'b1 || busy !== 1'b0 || reg_valid_write !== 1'b0)
        begin errors++; $display("FAIL no_reload_%0d got int %b busy %b wr %b want 1 0 0", k, timer_int, busy, reg_valid_write); end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_reload_with_read;
    logic [31:0] ed [1:5];
    ed = '{32'h0, 32'hffffffff, 32'h0, 32'h140, 32'h0};
    // trigger cycle T, host read arrives the same cycle
    auto_en = 1; period = 32'h40; host_rd_req = 1; host_addr = MTL;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b0 || reg_valid_read !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL trig_cycle got rdy %b rd %b busy %b want 0 0 0", host_ready, reg_valid_read, busy); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      checks++; if (busy !== 1'b1 || host_ready !== 1'b0 || reg_valid_read !== 1'b0)
        begin errors++; $display("FAIL seq_ctl_T%0d got busy %b rdy %b rd %b want 1 0 0", k, busy, host_ready, reg_valid_read); end
      checks++; if (reg_valid_write !== (k >= 2 && k <= 4))
        begin errors++; $display("FAIL seq_wr_T%0d got %b want %b", k, reg_valid_write, (k >= 2 && k <= 4)); end
      if (k >= 2 && k <= 4) begin
        checks++; if (reg_addr !== ((k == 3) ? CMPH : CMP) || reg_wdata !== ed[k])
          begin errors++; $display("FAIL seq_data_T%0d got %h=%h want %h=%h", k, reg_addr, reg_wdata, (k == 3) ? CMPH : CMP, ed[k]); end
      end
    end
    checks++; if (timer_int !== 1'b0 || reload_cnt !== 16'd1)
      begin errors++; $display("FAIL hold_state got int %b cnt %0d want 0 1", timer_int, reload_cnt); end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b1 || reg_valid_read !== 1'b1 || host_rdata_valid !== 1'b1 || host_rdata !== 32'h101 || busy !== 1'b0)
      begin errors++; $display("FAIL read_T6 got rdy %b rd %b v %b data %h busy %b want 1 1 1 101 0", host_ready, reg_valid_read, host_rdata_valid, host_rdata, busy); end
    @(posedge ACLK); #1;
    host_rd_req = 0;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_lo;
`ifdef CORE_TIMER_SCHED_SKIP_EN
    exp_lo = 32'h18;
`else
    exp_lo = 32'h10;
`endif
    auto_en = 0; host_wr_req = 1; host_addr = CMP; host_wdata = 32'hFFFFFFF0;
    @(posedge ACLK); #1;
    host_addr = CMPH; host_wdata = 32'hFFFFFFFF;
    @(posedge ACLK); #1;
    host_wr_req = 0; mtime = 64'hFFFFFFFF_FFFFFFF8;
    @(posedge ACLK); #1;
    auto_en = 1; period = 32'h20;
    @(negedge ACLK);
    checks++; if (host_ready !== 1'b0 || timer_int !== 1'b1)
      begin errors++; $display("FAIL wrap_trig got rdy %b int %b want 0 1", host_ready, timer_int); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge ACLK); #1;
      auto_en = 0;
      @(negedge ACLK);
      if (k == 3) begin
        checks++; if (reg_valid_write !== 1'b1 || reg_addr !== CMPH || reg_wdata !== 32'h0)
          begin errors++; $display("FAIL wrap_hi got %b %h=%h want 1 %h=0", reg_valid_write, reg_addr, reg_wdata, CMPH); end
      end
      if (k == 4) begin
        checks++; if (reg_valid_write !== 1'b1 || reg_addr !== CMP || reg_wdata !== exp_lo)
          begin errors++; $display("FAIL wrap_lo got %b %h=%h want 1 %h=%h", reg_valid_write, reg_addr, reg_wdata, CMP, exp_lo); end
      end
    end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checks++; if (busy !== 1'b0 || reload_cnt !== 16'd2 || host_ready !== 1'b1)
      begin errors++; $display("FAIL wrap_end got busy %b cnt %0d rdy %b want 0 2 1", busy, reload_cnt, host_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_lo [3];
    int nseq;
`ifdef CORE_TIMER_SCHED_SKIP_EN
    nseq = 1; exp_lo = '{32'h135, 32'h0, 32'h0};
`else
    nseq = 3; exp_lo = '{32'h110, 32'h120, 32'h130};
`endif
    @(posedge ACLK); #1;
    ARESET = 1; auto_en = 0;
    @(posedge ACLK); #1;
    ARESET = 0; host_wr_req = 1; host_addr = CMP; host_wdata = 32'h100; mtime = 64'h125;
    @(posedge ACLK); #1;
    host_addr = CMPH; host_wdata = 32'h0;
    @(posedge ACLK); #1;
    host_wr_req = 0; auto_en = 1; period = 32'h10;
    for (int s = 0; s < nseq; s++) begin
      @(negedge ACLK);
      checks++; if (busy !== 1'b0 || host_ready !== 1'b0)
        begin errors++; $display("FAIL b2b_trig_%0d got busy %b rdy %b want 0 0", s, busy, host_ready); end
      for (int k = 1; k <= 5; k++) begin
        @(posedge ACLK); #1;
        @(negedge ACLK);
        if (k == 4) begin
          checks++; if (reg_valid_write !== 1'b1 || reg_wdata !== exp_lo[s])
            begin errors++; $display("FAIL b2b_lo_%0d got %b %h want 1 %h", s, reg_valid_write, reg_wdata, exp_lo[s]); end
        end
      end
      @(posedge ACLK); #1;
    end
    @(negedge ACLK);
    checks++; if (busy !== 1'b0 || host_ready !== 1'b1 || reload_cnt !== 16'(nseq))
      begin errors++; $display("FAIL b2b_end got busy %b rdy %b cnt %0d want 0 1 %0d", busy, host_ready, reload_cnt, nseq); end
  endtask

  task automatic test_reset_mid;
    @(posedge ACLK); #1;
    mtime = 64'h200;
    for (int k = 0; k < 3; k++) begin
      @(posedge ACLK); #1;
    end
    // now at WR_H
    ARESET = 1;
    @(negedge ACLK);
    checks++; if (reg_valid_write !== 1'b0 || busy !== 1'b0 || host_ready !== 1'b0)
      begin errors++; $display("FAIL rst_at_wrh got wr %b busy %b rdy %b want 0 0 0", reg_valid_write, busy, host_ready); end
    @(posedge ACLK); #1;
    ARESET = 0; auto_en = 0;
    @(negedge ACLK);
    checks++; if (busy !== 1'b0 || reload_cnt !== 16'd0 || reg_valid_write !== 1'b0 || host_ready !== 1'b1)
      begin errors++; $display("FAIL rst_after got busy %b cnt %0d wr %b rdy %b want 0 0 0 1", busy, reload_cnt, reg_valid_write, host_ready); end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checks++; if (reg_valid_write !== 1'b0 || mtimecmp_m !== 64'hFFFFFFFF_FFFFFFFF)
      begin errors++; $display("FAIL rst_no_wrl got wr %b cmp %h want 0 ffffffffffffffff", reg_valid_write, mtimecmp_m); end
  endtask

  initial begin
    ARESET = 1; host_wr_req = 0; host_rd_req = 0; host_addr = 0; host_wdata = 0;
    auto_en = 0; period = 0; mtime = 0;
    test_reset();
    test_passthrough();
    test_reload_with_read();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
